// File: rtl/uart_pkt_tx.sv
// Multi-byte UART packet transmitter: valid/ready packet intake, back-to-back
// framing with configurable byte order, parity and stop bits.
module uart_pkt_tx #(
    parameter int unsigned CLK_FREQ  = 50000000,
    parameter int unsigned UART_BPS  = 9600,
    parameter int unsigned NUM_BYTES = 8,
    parameter int unsigned MSB_FIRST = 0,
    parameter int unsigned PARITY    = 0,
    parameter int unsigned STOP_BITS = 1,
    localparam int unsigned LEN_W    = $clog2(NUM_BYTES) + 1,
    localparam int unsigned IDX_W    = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst_n,
    input  logic                   pkt_valid,
    output logic                   pkt_ready,
    input  logic [8*NUM_BYTES-1:0] pkt_din,
    input  logic [LEN_W-1:0]       pkt_len,
    output logic                   tx_busy,
    output logic [IDX_W-1:0]       byte_idx,
    output logic                   pkt_done,
    output logic                   uart_txd
);

    localparam int unsigned BAUD_CNT = CLK_FREQ / UART_BPS;
    localparam int unsigned BAUD_W   = $clog2(BAUD_CNT);
    localparam int unsigned DIN_W    = 8 * NUM_BYTES;
    localparam bit          PAR_EN   = (PARITY == 1) || (PARITY == 2);
    localparam bit          PAR_ODD  = (PARITY == 1);
    localparam bit          TWO_STOP = (STOP_BITS == 2);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t             state, state_n;
    logic [BAUD_W-1:0]  baud_cnt, baud_cnt_n;
    logic [2:0]         bit_cnt, bit_cnt_n;
    logic               stop_cnt, stop_cnt_n;
    logic [IDX_W-1:0]   pos, pos_n;
    logic [DIN_W-1:0]   din_sh, din_sh_n;
    logic [LEN_W-1:0]   len_sh, len_sh_n;
    logic               txd_n, ready_n, busy_n, done_n;

    logic               baud_end;
    logic               last_byte;
    logic [LEN_W-1:0]   len_in;
    logic [7:0]         cur_byte;
    logic               par_bit;

    // Byte on the wire for position p, honouring the configured byte order.
    function automatic logic [7:0] sel_byte(input logic [DIN_W-1:0] data,
                                            input logic [LEN_W-1:0] len,
                                            input logic [IDX_W-1:0] p);
        logic [LEN_W-1:0] k;
        logic [7:0]       r;
        k = (MSB_FIRST != 0) ? LEN_W'(len - LEN_W'(1) - LEN_W'(p)) : LEN_W'(p);
        r = 8'h00;
        for (int unsigned i = 0; i < NUM_BYTES; i++) begin
            if (k == LEN_W'(i)) r = data[8*i +: 8];
        end
        return r;
    endfunction

    assign len_in    = ((pkt_len == '0) || (pkt_len > LEN_W'(NUM_BYTES))) ? LEN_W'(NUM_BYTES) : pkt_len;
    assign baud_end  = (baud_cnt == BAUD_W'(BAUD_CNT - 1));
    assign last_byte = (LEN_W'(pos) == LEN_W'(len_sh - LEN_W'(1)));
    assign cur_byte  = sel_byte(din_sh, len_sh, pos);
    assign par_bit   = PAR_ODD ? ~(^cur_byte) : ^cur_byte;

    // Next-state, counters and registered-output values
    always_comb begin
        state_n    = state;
        baud_cnt_n = baud_end ? '0 : BAUD_W'(baud_cnt + BAUD_W'(1));
        bit_cnt_n  = bit_cnt;
        stop_cnt_n = stop_cnt;
        pos_n      = pos;
        din_sh_n   = din_sh;
        len_sh_n   = len_sh;
        txd_n      = uart_txd;
        ready_n    = pkt_ready;
        busy_n     = tx_busy;
        done_n     = 1'b0;

        case (state)
            IDLE: begin
                baud_cnt_n = '0;
                if (pkt_valid && pkt_ready) begin
                    state_n  = START;
                    din_sh_n = pkt_din;
                    len_sh_n = len_in;
                    pos_n    = '0;
                    txd_n    = 1'b0;
                    ready_n  = 1'b0;
                    busy_n   = 1'b1;
                end
            end
            START: begin
                if (baud_end) begin
                    state_n   = DATA;
                    bit_cnt_n = 3'd0;
                    txd_n     = cur_byte[0];
                end
            end
            DATA: begin
                if (baud_end) begin
                    if (bit_cnt == 3'd7) begin
                        stop_cnt_n = 1'b0;
                        if (PAR_EN) begin
                            state_n = PAR;
                            txd_n   = par_bit;
                        end else begin
                            state_n = STOP;
                            txd_n   = 1'b1;
                        end
                    end else begin
                        bit_cnt_n = 3'(bit_cnt + 3'd1);
                        txd_n     = cur_byte[3'(bit_cnt + 3'd1)];
                    end
                end
            end
            PAR: begin
                if (baud_end) begin
                    state_n    = STOP;
                    stop_cnt_n = 1'b0;
                    txd_n      = 1'b1;
                end
            end
            STOP: begin
                if (baud_end) begin
                    if (TWO_STOP && !stop_cnt) begin
                        stop_cnt_n = 1'b1;
                    end else if (last_byte) begin
                        state_n = IDLE;
                        pos_n   = '0;
                        txd_n   = 1'b1;
                        ready_n = 1'b1;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                    end else begin
                        state_n = START;
                        pos_n   = IDX_W'(pos + IDX_W'(1));
                        txd_n   = 1'b0;
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            stop_cnt  <= 1'b0;
            pos       <= '0;
            din_sh    <= '0;
            len_sh    <= '0;
            uart_txd  <= 1'b1;
            pkt_ready <= 1'b1;
            tx_busy   <= 1'b0;
            pkt_done  <= 1'b0;
        end else begin
            state     <= state_n;
            baud_cnt  <= baud_cnt_n;
            bit_cnt   <= bit_cnt_n;
            stop_cnt  <= stop_cnt_n;
            pos       <= pos_n;
            din_sh    <= din_sh_n;
            len_sh    <= len_sh_n;
            uart_txd  <= txd_n;
            pkt_ready <= ready_n;
            tx_busy   <= busy_n;
            pkt_done  <= done_n;
        end
    end

    assign byte_idx = pos;

endmodule

// File: tb/tb_uart_pkt_tx.sv
// Directed bench for uart_pkt_tx: four instances cover default framing,
// MSB-first ordering, even parity with two stops, and odd parity.
module tb_uart_pkt_tx;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic [63:0] pkt_din;
    logic [3:0]  pkt_len;
    logic        vld  [4];
    logic        rdy  [4];
    logic        busy [4];
    logic        done [4];
    logic        txd  [4];
    logic [2:0]  idx  [4];

    int checks = 0;
    int errors = 0;
    bit exp_q[$];

    always #5 sys_clk = ~sys_clk;

    uart_pkt_tx #(.CLK_FREQ(1000), .UART_BPS(100), .NUM_BYTES(8), .MSB_FIRST(0), .PARITY(0), .STOP_BITS(1)) u_lsb (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .pkt_valid(vld[0]), .pkt_ready(rdy[0]), .pkt_din(pkt_din),
        .pkt_len(pkt_len), .tx_busy(busy[0]), .byte_idx(idx[0]), .pkt_done(done[0]), .uart_txd(txd[0]));
    uart_pkt_tx #(.CLK_FREQ(1000), .UART_BPS(100), .NUM_BYTES(8), .MSB_FIRST(1), .PARITY(0), .STOP_BITS(1)) u_msb (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .pkt_valid(vld[1]), .pkt_ready(rdy[1]), .pkt_din(pkt_din),
        .pkt_len(pkt_len), .tx_busy(busy[1]), .byte_idx(idx[1]), .pkt_done(done[1]), .uart_txd(txd[1]));
    uart_pkt_tx #(.CLK_FREQ(1000), .UART_BPS(100), .NUM_BYTES(8), .MSB_FIRST(0), .PARITY(2), .STOP_BITS(2)) u_even (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .pkt_valid(vld[2]), .pkt_ready(rdy[2]), .pkt_din(pkt_din),
        .pkt_len(pkt_len), .tx_busy(busy[2]), .byte_idx(idx[2]), .pkt_done(done[2]), .uart_txd(txd[2]));
    uart_pkt_tx #(.CLK_FREQ(1000), .UART_BPS(100), .NUM_BYTES(8), .MSB_FIRST(0), .PARITY(1), .STOP_BITS(1)) u_odd (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .pkt_valid(vld[3]), .pkt_ready(rdy[3]), .pkt_din(pkt_din),
        .pkt_len(pkt_len), .tx_busy(busy[3]), .byte_idx(idx[3]), .pkt_done(done[3]), .uart_txd(txd[3]));

    // Expected line level per clock for one frame at 10 clocks per bit.
    function automatic void push_frame(input logic [7:0] b, input int par, input int stopn);
        for (int c = 0; c < 10; c++) exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++)
            for (int c = 0; c < 10; c++) exp_q.push_back(b[i]);
        if (par == 1) for (int c = 0; c < 10; c++) exp_q.push_back(~(^b));
        if (par == 2) for (int c = 0; c < 10; c++) exp_q.push_back(^b);
        for (int c = 0; c < 10 * stopn; c++) exp_q.push_back(1'b1);
    endfunction

    task automatic test_reset();
        sys_rst_n = 1'b0;
        pkt_din   = '0;
        pkt_len   = '0;
        for (int m = 0; m < 4; m++) vld[m] = 1'b0;
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (2) @(negedge sys_clk);
        for (int m = 0; m < 4; m++) begin
            checks++;
            if (txd[m] !== 1'b1 || rdy[m] !== 1'b1 || busy[m] !== 1'b0 || done[m] !== 1'b0 || idx[m] !== 3'd0) begin
                errors++;
                $display("FAIL reset inst%0d: txd=%b rdy=%b busy=%b done=%b idx=%0d, want 1 1 0 0 0",
                         m, txd[m], rdy[m], busy[m], done[m], idx[m]);
            end
        end
    endtask

    // Single 0x55 byte: start low 1..10, 1010_1010 LSB first, stop, done at 101.
    task automatic test_basic();
        int  n;
        bit  e;
        exp_q.delete();
        push_frame(8'h55, 0, 1);
        n = exp_q.size();
        @(negedge sys_clk);
        pkt_din = 64'h0000_0000_0000_0055;
        pkt_len = 4'd1;
        vld[0]  = 1'b1;
        for (int k = 1; k <= n + 1; k++) begin
            @(negedge sys_clk);
            if (k == 1) vld[0] = 1'b0;
            e = (k <= n) ? exp_q[k-1] : 1'b1;
            checks++;
            if (txd[0] !== e) begin errors++; $display("FAIL basic txd k=%0d got %b want %b", k, txd[0], e); end
            checks++;
            if (done[0] !== (k == n + 1)) begin errors++; $display("FAIL basic done k=%0d got %b", k, done[0]); end
            checks++;
            if (busy[0] !== (k <= n)) begin errors++; $display("FAIL basic busy k=%0d got %b", k, busy[0]); end
        end
    endtask

    task automatic test_full_packet();
        int       n;
        bit       e;
        bit [2:0] ei;
        exp_q.delete();
        for (int b = 1; b <= 8; b++) push_frame(8'(b), 0, 1);
        n = exp_q.size();
        @(negedge sys_clk);
        pkt_din = 64'h0807_0605_0403_0201;
        pkt_len = 4'd0;
        vld[0]  = 1'b1;
        for (int k = 1; k <= n + 1; k++) begin
            @(negedge sys_clk);
            if (k == 1) vld[0] = 1'b0;
            e  = (k <= n) ? exp_q[k-1] : 1'b1;
            ei = (k <= n) ? 3'((k - 1) / 100) : 3'd0;
            checks++;
            if (txd[0] !== e) begin errors++; $display("FAIL full txd k=%0d got %b want %b", k, txd[0], e); end
            checks++;
            if (idx[0] !== ei) begin errors++; $display("FAIL full byte_idx k=%0d got %0d want %0d", k, idx[0], ei); end
            checks++;
            if (done[0] !== (k == 801)) begin errors++; $display("FAIL full done k=%0d got %b", k, done[0]); end
        end
    endtask

    // MSB-first with length 3: upper bytes are filler and must never appear.
    task automatic test_order_len();
        int n;
        bit e;
        exp_q.delete();
        push_frame(8'h03, 0, 1);
        push_frame(8'h02, 0, 1);
        push_frame(8'h01, 0, 1);
        n = exp_q.size();
        @(negedge sys_clk);
        pkt_din = 64'hAAAA_AAAA_AA03_0201;
        pkt_len = 4'd3;
        vld[1]  = 1'b1;
        for (int k = 1; k <= n + 1; k++) begin
            @(negedge sys_clk);
            if (k == 1) vld[1] = 1'b0;
            e = (k <= n) ? exp_q[k-1] : 1'b1;
            checks++;
            if (txd[1] !== e) begin errors++; $display("FAIL order txd k=%0d got %b want %b", k, txd[1], e); end
            checks++;
            if (done[1] !== (k == 301)) begin errors++; $display("FAIL order done k=%0d got %b", k, done[1]); end
        end
    endtask

    // 0x07: even parity bit 1 (120-clock frame), odd parity bit 0 (110 clocks).
    task automatic test_parity_stop();
        int n;
        bit e;
        for (int m = 2; m <= 3; m++) begin
            exp_q.delete();
            push_frame(8'h07, (m == 2) ? 2 : 1, (m == 2) ? 2 : 1);
            n = exp_q.size();
            @(negedge sys_clk);
            pkt_din = 64'h0000_0000_0000_0007;
            pkt_len = 4'd1;
            vld[m]  = 1'b1;
            for (int k = 1; k <= n + 1; k++) begin
                @(negedge sys_clk);
                if (k == 1) vld[m] = 1'b0;
                e = (k <= n) ? exp_q[k-1] : 1'b1;
                checks++;
                if (txd[m] !== e) begin errors++; $display("FAIL parity%0d txd k=%0d got %b want %b", m, k, txd[m], e); end
                if (k == 95) begin
                    checks++;
                    if (txd[m] !== ((m == 2) ? 1'b1 : 1'b0)) begin
                        errors++; $display("FAIL parity%0d bit got %b", m, txd[m]);
                    end
                end
                checks++;
                if (done[m] !== (k == ((m == 2) ? 121 : 111))) begin
                    errors++; $display("FAIL parity%0d done k=%0d got %b", m, k, done[m]);
                end
            end
        end
    endtask

    // Valid held across pkt_done; din changed after first accept.
    task automatic test_back_to_back();
        int n;
        int ready_cnt;
        bit e;
        exp_q.delete();
        push_frame(8'h55, 0, 1);
        exp_q.push_back(1'b1);
        push_frame(8'hA3, 0, 1);
        n = exp_q.size();
        ready_cnt = 0;
        @(negedge sys_clk);
        pkt_din = 64'h0000_0000_0000_0055;
        pkt_len = 4'd1;
        vld[0]  = 1'b1;
        for (int k = 1; k <= n + 1; k++) begin
            @(negedge sys_clk);
            if (k == 1) pkt_din = 64'h0000_0000_0000_00A3;
            if (k == 102) vld[0] = 1'b0;
            if (k <= n && rdy[0] === 1'b1) ready_cnt++;
            e = (k <= n) ? exp_q[k-1] : 1'b1;
            checks++;
            if (txd[0] !== e) begin errors++; $display("FAIL b2b txd k=%0d got %b want %b", k, txd[0], e); end
            checks++;
            if (done[0] !== (k == 101 || k == 202)) begin errors++; $display("FAIL b2b done k=%0d got %b", k, done[0]); end
            checks++;
            if (busy[0] !== (k <= 201 && k != 101)) begin errors++; $display("FAIL b2b busy k=%0d got %b", k, busy[0]); end
        end
        checks++;
        if (ready_cnt != 1) begin errors++; $display("FAIL b2b ready cycles got %0d want 1", ready_cnt); end
    endtask

    task automatic test_reset_mid();
        int n;
        int done_seen;
        bit e;
        @(negedge sys_clk);
        pkt_din = 64'h0000_0000_0003_0201;
        pkt_len = 4'd3;
        vld[0]  = 1'b1;
        for (int k = 1; k <= 115; k++) begin
            @(negedge sys_clk);
            if (k == 1) vld[0] = 1'b0;
        end
        // k=115 is bit 0 of byte 0x02, a low data bit
        checks++;
        if (txd[0] !== 1'b0 || idx[0] !== 3'd1) begin
            errors++; $display("FAIL midreset pre txd=%b idx=%0d want 0 1", txd[0], idx[0]);
        end
        sys_rst_n = 1'b0;
        #1;
        checks++;
        if (txd[0] !== 1'b1 || rdy[0] !== 1'b1 || busy[0] !== 1'b0 || idx[0] !== 3'd0) begin
            errors++; $display("FAIL midreset txd=%b rdy=%b busy=%b idx=%0d want 1 1 0 0", txd[0], rdy[0], busy[0], idx[0]);
        end
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        done_seen = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge sys_clk);
            if (done[0] !== 1'b0 || txd[0] !== 1'b1) done_seen++;
        end
        checks++;
        if (done_seen != 0) begin errors++; $display("FAIL midreset residue cycles got %0d want 0", done_seen); end
        exp_q.delete();
        push_frame(8'h3C, 0, 1);
        n = exp_q.size();
        pkt_din = 64'h0000_0000_0000_003C;
        pkt_len = 4'd1;
        vld[0]  = 1'b1;
        for (int k = 1; k <= n + 1; k++) begin
            @(negedge sys_clk);
            if (k == 1) vld[0] = 1'b0;
            e = (k <= n) ? exp_q[k-1] : 1'b1;
            checks++;
            if (txd[0] !== e) begin errors++; $display("FAIL postreset txd k=%0d got %b want %b", k, txd[0], e); end
            checks++;
            if (done[0] !== (k == n + 1)) begin errors++; $display("FAIL postreset done k=%0d got %b", k, done[0]); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full_packet();
        test_order_len();
        test_parity_stop();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
